masked_hpc3_mul_chain: RTL

Parametrised chain of NUM_STAGES masked HPC3 multipliers with a valid-tracking pipeline. The block generalises the two-gadget HPC3 composition test: stage 0 computes a·b, and each stage k≥1 multiplies stage k-1's output by b. The block re-times b internally so every stage sees the matching b shares. It sits next to the AES S-box gadgets as the composition/latency testbed for multi-stage HPC3 products, and is the reference for probing-security evaluation of deep gadget chains.

---
 rtl/masked_hpc3_mul_chain.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/masked_hpc3_mul_chain.sv
// Chain of NUM_STAGES masked HPC3 multipliers: stage 0 computes a*b, stage k>=1
// multiplies stage k-1's product by b re-timed by k cycles, with a tracked valid pipeline.

module masked_hpc3_mul #(
  parameter  int NUM_SHARES    = 2,
  parameter  int BIT_WIDTH     = 1,
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]      a,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]      b,
  input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]   r,
  input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]   p,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]      c
);

  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] u_nxt_s;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] v_nxt_s;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] u_r;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] v_r;

  // Pair (i,j) and (j,i) share one r and one p word; r cancels across shares i and j,
  // p cancels inside share i because it blinds both u_ij and v_ij.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
      if (i == j) begin : g_diag
        assign u_nxt_s[i][j] = a[i] & b[i];
        assign v_nxt_s[i][j] = '0;
      end else begin : g_cross
        localparam int LO   = (i < j) ? i : j;
        localparam int HI   = (i < j) ? j : i;
        localparam int PIDX = LO * NUM_SHARES - (LO * (LO + 1)) / 2 + (HI - LO - 1);
        assign u_nxt_s[i][j] = (a[i] & (b[j] ^ r[PIDX])) ^ p[PIDX];
        assign v_nxt_s[i][j] = (~a[i] & r[PIDX]) ^ p[PIDX];
      end
    end
  end

  // Register layer that isolates every partial product before compression.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_r <= '0;
      v_r <= '0;
    end else begin
      u_r <= u_nxt_s;
      v_r <= v_nxt_s;
    end
  end

  // Share-local compression of registered terms only.
  always_comb begin
    c = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        c[i] = c[i] ^ u_r[i][j] ^ v_r[i][j];
      end
    end
  end

endmodule

module masked_hpc3_mul_chain #(
  parameter  int NUM_SHARES    = 2,
  parameter  int BIT_WIDTH     = 1,
  parameter  int NUM_STAGES    = 2,
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2,
  localparam int COUNT_W       = $clog2(NUM_STAGES + 1)
) (
  input  logic                                                     in_clock,
  input  logic                                                     in_reset,
  input  logic                                                     in_valid,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                     in_a,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                     in_b,
  input  logic [NUM_STAGES-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]  in_r,
  input  logic [NUM_STAGES-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]  in_p,
  output logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]     out_c,
  output logic [NUM_STAGES-1:0]                                    out_valid,
  output logic                                                     out_busy,
  output logic [COUNT_W-1:0]                                       out_count
);

  logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] a_stage_s;
  logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] b_stage_s;
  logic [NUM_STAGES-1:0]                                valid_r;
  logic [COUNT_W-1:0]                                   count_r;
  logic [COUNT_W-1:0]                                   count_nxt_s;
  logic                                                 busy_r;

  assign a_stage_s[0] = in_a;
  assign b_stage_s[0] = in_b;

  if (NUM_STAGES > 1) begin : g_bdly
    logic [NUM_STAGES-1:1][NUM_SHARES-1:0][BIT_WIDTH-1:0] b_dly_r;

    // b shares stay in separate registers so no share pair ever meets outside a gadget.
    always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
        b_dly_r <= '0;
      end else begin
        b_dly_r[1] <= in_b;
        for (int k = 2; k < NUM_STAGES; k++) begin
          b_dly_r[k] <= b_dly_r[k-1];
        end
      end
    end

    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_link
      assign a_stage_s[k] = out_c[k-1];
      assign b_stage_s[k] = b_dly_r[k];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    masked_hpc3_mul #(
      .NUM_SHARES (NUM_SHARES),
      .BIT_WIDTH  (BIT_WIDTH)
    ) u_mul (
      .clk   (in_clock),
      .rst_n (in_reset),
      .a     (a_stage_s[k]),
      .b     (b_stage_s[k]),
      .r     (in_r[k]),
      .p     (in_p[k]),
      .c     (out_c[k])
    );
  end

  // Up/down occupancy: accept adds one, retirement from the last stage removes one.
  always_comb begin
    count_nxt_s = count_r;
    case ({in_valid, valid_r[NUM_STAGES-1]})
      2'b10:   count_nxt_s = count_r + COUNT_W'(1);
      2'b01:   count_nxt_s = count_r - COUNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Valid shift register and registered occupancy outputs.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      valid_r <= '0;
      count_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      valid_r[0] <= in_valid;
      for (int k = 1; k < NUM_STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
      end
      count_r <= count_nxt_s;
      busy_r  <= (count_nxt_s != COUNT_W'(0));
    end
  end

  assign out_valid = valid_r;
  assign out_count = count_r;
  assign out_busy  = busy_r;

endmodule
